// File: rtl/fetch_pkg.sv
// Shared constants for the fetch unit: default vectors, instruction width, counter sizing.
package fetch_pkg;

   localparam int unsigned INST_W        = 32;
   localparam logic [31:0] RESET_VEC_DEF = 32'hBFC0_0000;
   localparam logic [31:0] EXC_VEC_DEF   = 32'hBFC0_0380;
   localparam int unsigned MAX_OUT_DEF   = 2;
   localparam int unsigned CNT_W         = $clog2(MAX_OUT_DEF + 1);

   // Counter width able to hold 0..max_out inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_out);
      return $clog2(max_out + 1);
   endfunction

endpackage

// File: rtl/pc_inflight_fifo.sv
// Small synchronous FIFO holding the PC of every accepted fetch request, oldest at the head.
module pc_inflight_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CntW'(DEPTH));
   assign head_o  = mem_q[rptr_q];
   assign pop_ok  = pop_i & ~empty_o;
   // A push into a full FIFO is fine when the head leaves in the same cycle.
   assign push_ok = push_i & (~full_o | pop_ok);

   always_comb begin
      wptr_d = push_ok ? ptr_inc(wptr_q) : wptr_q;
      rptr_d = pop_ok ? ptr_inc(rptr_q) : rptr_q;
      cnt_d  = cnt_q;
      if (push_ok && !pop_ok) begin
         cnt_d = cnt_q + CntW'(1);
      end else if (!push_ok && pop_ok) begin
         cnt_d = cnt_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         if (push_ok) begin
            mem_q[wptr_q] <= data_i;
         end
      end
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC generation and instruction-SRAM request control with redirect handling and
// wrong-path response dropping.
module pc_fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
   parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(EXC_VEC_DEF),
   parameter int unsigned       MAX_OUT   = MAX_OUT_DEF,
   parameter int unsigned       INC       = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pc_stall,
   input  logic              busy,
   input  logic              exc_valid,
   input  logic              exc_use_vec,
   input  logic [ADDR_W-1:0] exc_target,
   input  logic              br_valid,
   input  logic [ADDR_W-1:0] br_target,
   output logic              inst_req,
   output logic [ADDR_W-1:0] inst_addr,
   input  logic              inst_addr_ok,
   input  logic              inst_data_ok,
   input  logic [INST_W-1:0] inst_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic              if_valid,
   output logic [ADDR_W-1:0] if_pc,
   output logic [INST_W-1:0] if_inst
);

   localparam int unsigned CntW = cnt_width(MAX_OUT);

   logic              run_q;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [CntW-1:0]   out_cnt_q, out_cnt_d;
   logic [CntW-1:0]   discard_q, discard_d;
   logic              if_valid_q, if_valid_d;
   logic [ADDR_W-1:0] if_pc_q, if_pc_d;
   logic [INST_W-1:0] if_inst_q, if_inst_d;

   logic              stall, br_apply, redirect, accept, resp, deliver;
   logic              fifo_empty, fifo_full;
   logic [ADDR_W-1:0] fifo_head;

   assign stall    = pc_stall | busy;
   assign br_apply = br_valid & ~exc_valid & ~stall;
   assign redirect = exc_valid | br_apply;
   assign inst_req = run_q & ~stall & ~exc_valid & ~br_valid & ~fifo_full
                     & (out_cnt_q < CntW'(MAX_OUT));
   assign accept   = inst_req & inst_addr_ok;
   // Responses with nothing in flight are protocol violations and are ignored.
   assign resp     = inst_data_ok & ~fifo_empty;
   assign deliver  = resp & (discard_q == '0) & ~redirect;

   assign inst_addr = pc_q;
   assign pc        = pc_q;
   assign if_valid  = if_valid_q;
   assign if_pc     = if_pc_q;
   assign if_inst   = if_inst_q;

   always_comb begin
      pc_d = pc_q;
      if (exc_valid) begin
         pc_d = exc_use_vec ? EXC_VEC : exc_target;
      end else if (br_apply) begin
         pc_d = br_target;
      end else if (accept) begin
         pc_d = pc_q + ADDR_W'(INC);
      end
   end

   always_comb begin
      out_cnt_d = out_cnt_q;
      if (accept && !resp) begin
         out_cnt_d = out_cnt_q + CntW'(1);
      end else if (!accept && resp) begin
         out_cnt_d = out_cnt_q - CntW'(1);
      end
   end

   // Everything still in flight after a redirect is wrong-path and gets dropped.
   always_comb begin
      discard_d = discard_q;
      if (redirect) begin
         discard_d = out_cnt_q - CntW'(resp);
      end else if (resp && (discard_q != '0)) begin
         discard_d = discard_q - CntW'(1);
      end
   end

   always_comb begin
      if_valid_d = deliver;
      if_pc_d    = deliver ? fifo_head : if_pc_q;
      if_inst_d  = deliver ? inst_rdata : if_inst_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_q      <= 1'b0;
         pc_q       <= RESET_VEC;
         out_cnt_q  <= '0;
         discard_q  <= '0;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_inst_q  <= '0;
      end else begin
         run_q      <= 1'b1;
         pc_q       <= pc_d;
         out_cnt_q  <= out_cnt_d;
         discard_q  <= discard_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_inst_q  <= if_inst_d;
      end
   end

   pc_inflight_fifo #(
      .DEPTH (MAX_OUT),
      .WIDTH (ADDR_W)
   ) u_inflight_fifo (
      .clk_i   (clk),
      .rst_ni  (reset),
      .push_i  (accept),
      .data_i  (pc_q),
      .pop_i   (resp),
      .head_o  (fifo_head),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed plus randomized bench for pc_fetch_ctrl against a request-level reference model.
module tb_pc_fetch_ctrl;

   localparam int unsigned MAX_OUT   = 2;
   localparam logic [31:0] RESET_VEC = 32'hBFC0_0000;
   localparam logic [31:0] EXC_VEC   = 32'hBFC0_0380;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        pc_stall = 1'b0, busy = 1'b0;
   logic        exc_valid = 1'b0, exc_use_vec = 1'b0;
   logic [31:0] exc_target = '0;
   logic        br_valid = 1'b0;
   logic [31:0] br_target = '0;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
   logic [31:0] inst_rdata = '0;
   logic [31:0] pc;
   logic        if_valid;
   logic [31:0] if_pc, if_inst;

   always #5 clk = ~clk;

   pc_fetch_ctrl #(
      .ADDR_W    (32),
      .RESET_VEC (RESET_VEC),
      .EXC_VEC   (EXC_VEC),
      .MAX_OUT   (MAX_OUT),
      .INC       (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pc_stall     (pc_stall),
      .busy         (busy),
      .exc_valid    (exc_valid),
      .exc_use_vec  (exc_use_vec),
      .exc_target   (exc_target),
      .br_valid     (br_valid),
      .br_target    (br_target),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .pc           (pc),
      .if_valid     (if_valid),
      .if_pc        (if_pc),
      .if_inst      (if_inst)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: fetch PC plus the list of outstanding requests, each tagged wrong-path
   // once any redirect has happened after it was issued.
   logic [31:0] m_pc = RESET_VEC;
   bit          m_run = 1'b0;
   logic [31:0] mq_addr[$];
   bit          mq_stale[$];
   bit          e_if_valid = 1'b0;
   logic [31:0] e_if_pc = '0, e_if_inst = '0;
   bit          br_pend = 1'b0;
   logic [31:0] br_tgt = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge with inputs set; checks, advances the model, ends at next fall.
   task automatic step();
      bit          stall, exp_req, redirect, resp, s;
      logic [31:0] a;
      inst_rdata = (mq_addr.size() > 0) ? mem_word(mq_addr[0]) : $urandom;
      #1;
      stall   = pc_stall | busy;
      exp_req = m_run && !stall && !exc_valid && !br_valid && (mq_addr.size() < int'(MAX_OUT));
      chk("inst_req", {31'd0, inst_req}, {31'd0, exp_req});
      chk("inst_addr", inst_addr, m_pc);
      chk("pc", pc, m_pc);
      chk("if_valid", {31'd0, if_valid}, {31'd0, e_if_valid});
      if (e_if_valid) begin
         chk("if_pc", if_pc, e_if_pc);
         chk("if_inst", if_inst, e_if_inst);
      end
      redirect   = exc_valid || (br_valid && !stall);
      resp       = inst_data_ok && (mq_addr.size() > 0);
      e_if_valid = 1'b0;
      if (resp) begin
         a = mq_addr.pop_front();
         s = mq_stale.pop_front();
         if (!s && !redirect) begin
            e_if_valid = 1'b1;
            e_if_pc    = a;
            e_if_inst  = mem_word(a);
         end
      end
      if (redirect) begin
         foreach (mq_stale[i]) mq_stale[i] = 1'b1;
         m_pc = exc_valid ? (exc_use_vec ? EXC_VEC : exc_target) : br_target;
      end else if (exp_req && inst_addr_ok) begin
         mq_addr.push_back(m_pc);
         mq_stale.push_back(1'b0);
         m_pc = m_pc + 32'd4;
      end
      m_run = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      pc_stall = 1'b0; busy = 1'b0; exc_valid = 1'b0; exc_use_vec = 1'b0;
      br_valid = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
   endtask

   // Holds reset for the given cycles, checking reset values; returns at the release edge.
   task automatic do_reset(input int cycles);
      reset = 1'b0;
      idle_inputs();
      mq_addr.delete();
      mq_stale.delete();
      m_pc = RESET_VEC; m_run = 1'b0; e_if_valid = 1'b0; br_pend = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         #1;
         chk("rst_pc", pc, RESET_VEC);
         chk("rst_req", {31'd0, inst_req}, 32'd0);
         chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
         chk("rst_if_pc", if_pc, 32'd0);
         chk("rst_if_inst", if_inst, 32'd0);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic drain();
      idle_inputs();
      for (int i = 0; (i < int'(MAX_OUT) + 2) && (mq_addr.size() > 0); i++) begin
         inst_data_ok = 1'b1;
         step();
      end
      inst_data_ok = 1'b0;
      step();
   endtask

   initial begin
      do_reset(3);
      step();  // run not yet set: no request in the first cycle after release

      // Sequential fetch with responses one cycle after acceptance
      inst_addr_ok = 1'b1;
      chk("t1_addr0", inst_addr, 32'hBFC0_0000);
      step();
      inst_data_ok = 1'b1;
      chk("t1_addr1", inst_addr, 32'hBFC0_0004);
      step();
      chk("t1_addr2", inst_addr, 32'hBFC0_0008);
      chk("t1_ifpc0", if_pc, 32'hBFC0_0000);
      step();
      chk("t1_ifpc1", if_pc, 32'hBFC0_0004);
      step();
      drain();

      // Stall with one outstanding: no new requests, response still delivered
      inst_addr_ok = 1'b1;
      step();
      pc_stall = 1'b1;
      step();
      step();
      inst_data_ok = 1'b1;
      step();
      chk("t2_if_valid", {31'd0, if_valid}, 32'd1);
      drain();

      // Exception during busy with two outstanding: both responses dropped
      inst_addr_ok = 1'b1;
      step();
      step();
      inst_addr_ok = 1'b0;
      busy = 1'b1; exc_valid = 1'b1; exc_use_vec = 1'b1;
      step();
      exc_valid = 1'b0;
      chk("t3_pc", pc, EXC_VEC);
      inst_data_ok = 1'b1;
      step();
      step();
      chk("t3_dropped", {31'd0, if_valid}, 32'd0);
      busy = 1'b0; inst_data_ok = 1'b0; inst_addr_ok = 1'b1;
      step();
      inst_addr_ok = 1'b0; inst_data_ok = 1'b1;
      step();
      chk("t3_first_new", if_pc, EXC_VEC);
      drain();

      // Exception beats a same-cycle branch
      br_valid = 1'b1; br_target = 32'h8000_1000;
      exc_valid = 1'b1; exc_use_vec = 1'b0; exc_target = 32'h8000_2000;
      step();
      br_valid = 1'b0; exc_valid = 1'b0;
      chk("t4_pc", pc, 32'h8000_2000);

      // Outstanding limit
      inst_addr_ok = 1'b1;
      step();
      step();
      chk("t5_req_full", {31'd0, inst_req}, 32'd0);
      step();
      inst_data_ok = 1'b1;
      step();
      inst_data_ok = 1'b0;
      chk("t5_req_again", {31'd0, inst_req}, 32'd1);
      step();
      drain();

      // Address wrap-around
      exc_valid = 1'b1; exc_use_vec = 1'b0; exc_target = 32'hFFFF_FFFC;
      step();
      exc_valid = 1'b0; inst_addr_ok = 1'b1;
      chk("t6_addr_hi", inst_addr, 32'hFFFF_FFFC);
      step();
      chk("t6_wrap", inst_addr, 32'h0000_0000);
      step();
      drain();

      // Response with nothing in flight must be ignored
      inst_data_ok = 1'b1;
      step();
      inst_data_ok = 1'b0;
      step();

      // Randomized traffic with one mid-run reset
      for (int c = 0; c < 400; c++) begin
         if (c == 200) begin
            do_reset(2);
         end
         pc_stall    = ($urandom_range(0, 9) < 2);
         busy        = ($urandom_range(0, 9) == 0);
         exc_valid   = ($urandom_range(0, 29) == 0);
         exc_use_vec = ($urandom_range(0, 1) == 1);
         exc_target  = $urandom & 32'hFFFF_FFFC;
         if (!br_pend && ($urandom_range(0, 14) == 0)) begin
            br_pend = 1'b1;
            br_tgt  = $urandom & 32'hFFFF_FFFC;
         end
         br_valid     = br_pend;
         br_target    = br_tgt;
         inst_addr_ok = ($urandom_range(0, 9) < 7);
         inst_data_ok = (mq_addr.size() > 0) && ($urandom_range(0, 1) == 1);
         if (exc_valid || (br_pend && !(pc_stall || busy))) br_pend = 1'b0;
         step();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Parametrised next-generation PC and fetch-request unit for the MIPS pipeline. It holds the fetch PC and issues addresses on the instruction-SRAM request/response handshake with up to MAX_OUT requests in flight. It tracks the PC of every accepted request and delivers {pc, inst} to the IF/ID stage. It applies exception and branch redirects, and drops responses that belong to the wrong path.

Parameters:
ADDR_W, 32, fetch address width
RESET_VEC, 32'hBFC0_0000, PC loaded while reset is asserted
EXC_VEC, 32'hBFC0_0380, general exception entry
MAX_OUT, 2, maximum outstanding fetch requests (1..4)
INC, 4, sequential PC increment

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
pc_stall  in  1  pipeline hazard stall; blocks new requests and branch redirects
busy  in  1  multi-cycle unit busy; same effect as pc_stall
exc_valid  in  1  exception/eret redirect; applied regardless of stall/busy
exc_use_vec  in  1  1: target EXC_VEC; 0: target exc_target (eret/EPC)
exc_target  in  ADDR_W  explicit exception/eret target
br_valid  in  1  branch/jump redirect; producer holds it until applied
br_target  in  ADDR_W  branch target
inst_req  out  1  fetch request valid
inst_addr  out  ADDR_W  fetch address (equals pc)
inst_addr_ok  in  1  request accepted this cycle
inst_data_ok  in  1  response for the oldest outstanding request
inst_rdata  in  32  response instruction word
pc  out  ADDR_W  current fetch PC
if_valid  out  1  registered: delivered instruction valid
if_pc  out  ADDR_W  PC of the delivered instruction
if_inst  out  32  delivered instruction

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Port names are clk and reset.
- Values while reset=0: pc=RESET_VEC, out_cnt=0, discard_cnt=0, FIFO empty, run=0, if_valid=0, if_pc=0, if_inst=0.
- run: set on the first clk edge after reset deasserts. Requests start one cycle after release.
- Redirect priority: exc_valid > br_valid > sequential. When both are valid, exc wins and br is ignored that cycle.
- exc_valid=1: pc <= exc_use_vec ? EXC_VEC : exc_target, independent of pc_stall/busy.
- br_valid=1, exc_valid=0, pc_stall=0, busy=0: pc <= br_target.
- br_valid while stalled: no effect. The producer holds br_valid.
- inst_req = run & !pc_stall & !busy & !exc_valid & !br_valid & (out_cnt < MAX_OUT). It is combinational; inst_addr = pc.
- Accept (inst_req & inst_addr_ok): push pc into the in-flight FIFO; pc <= pc+INC, wrapping mod 2^ADDR_W.
- out_cnt: +1 on accept, -1 on inst_data_ok, unchanged when both occur in the same cycle.
- Response (inst_data_ok): pop the FIFO head.
  - If discard_cnt>0 or a redirect is applied this cycle: drop the response and decrement discard_cnt if it is nonzero.
  - Otherwise: next edge if_valid=1, if_pc=head, if_inst=inst_rdata (1-cycle latency).
- On a redirect: discard_cnt <= out_cnt - (inst_data_ok ? 1 : 0) (current discard_cnt is subsumed), and if_valid forced 0 next cycle.
- if_valid is a one-cycle pulse per response. IF/ID must accept it; pc_stall does not suppress delivery.
- inst_data_ok with an empty FIFO is a protocol violation: ignored, no state change, flagged by a bench assertion.
- Targets are used verbatim with no alignment correction. Misalignment (AdEL) is detected downstream.
- Reset asserted mid-operation: all state clears immediately. Late responses after release are not tracked; the memory side is also reset.

Decomposition:
- fetch_pkg: default RESET_VEC/EXC_VEC, INST_W=32, localparam CNT_W=$clog2(MAX_OUT+1).
- Sub-module pc_inflight_fifo: synchronous FIFO, depth MAX_OUT, width ADDR_W, push/pop/head/empty/full, same asynchronous active-low reset.
- Top level: run flag, pc register, counters, output register.

Test Plan:
- Reset low 3 cycles then high; addr_ok=1, data_ok 1 cycle after accept -> inst_addr BFC0_0000, BFC0_0004, BFC0_0008; if_pc same sequence, each with a one-cycle if_valid.
- pc_stall=1 for 3 cycles with 1 outstanding -> inst_req=0, pc holds; the returning data_ok still produces if_valid with the correct if_pc.
- busy=1, 2 outstanding, exc_valid with exc_use_vec=1 -> next inst_addr BFC0_0380; both old responses dropped (no if_valid); first new if_pc=BFC0_0380.
- Same-cycle br_valid (8000_1000) and exc_valid (exc_use_vec=0, exc_target 8000_2000) -> pc=8000_2000; br ignored.
- MAX_OUT=2, addr_ok=1, data_ok withheld -> exactly 2 accepts, then inst_req=0; one data_ok -> a third request accepted the following cycle.
- exc_target FFFF_FFFC, exc_use_vec=0 -> requests FFFF_FFFC then 0000_0000 (wrap).
